mix_columns_iter: RTL



---
 rtl/aes_pkg.sv | 42 ++++
 rtl/mix_column_word.sv | 29 ++
 rtl/mix_columns_iter.sv | 98 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, FSM encoding and GF(2^8) multiply helpers.
package aes_pkg;

    localparam int unsigned NB = 4;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        gmul2 = xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        gmul3 = xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        gmul9 = xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        gmul11 = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        gmul13 = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        gmul14 = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column (row 0 in the MSB).
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] a [4];

    always_comb begin
        col_out = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            a[r] = col_in[31-8*r -: 8];
        end
        // Each output row uses the base matrix row rotated right by the row number.
        for (int unsigned r = 0; r < 4; r++) begin
            if (inv) begin
                col_out[31-8*r -: 8] = gmul14(a[r])         ^ gmul11(a[(r+1)%4]) ^
                                       gmul13(a[(r+2)%4])   ^ gmul9(a[(r+3)%4]);
            end else begin
                col_out[31-8*r -: 8] = gmul2(a[r])          ^ gmul3(a[(r+1)%4]) ^
                                       a[(r+2)%4]           ^ a[(r+3)%4];
            end
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(NB - COLS_PER_CYCLE);

    mc_state_e  state, state_nxt;
    logic [1:0] col_idx;
    aes_state_t src;
    aes_state_t res;
    aes_state_t res_nxt;
    logic       inv_r;
    logic       accept;

    logic [31:0] col_sel [COLS_PER_CYCLE];
    logic [31:0] col_mix [COLS_PER_CYCLE];

    assign in_ready  = rst_n && (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign state_out = res;
    assign accept    = (state == ST_IDLE) && in_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)              state_nxt = ST_BUSY;
            ST_BUSY: if (col_idx == COL_LAST)   state_nxt = ST_DONE;
            ST_DONE: if (out_ready)             state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            col_sel[g] = src[32*(NB-1-int'(col_idx + 2'(g))) +: 32];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
            mix_column_word u_mix (
                .col_in  (col_sel[gi]),
                .inv     (inv_r),
                .col_out (col_mix[gi])
            );
        end
    endgenerate

    // Kept apart from the select block so the mux -> mixer -> writeback path has no false loop.
    always_comb begin
        res_nxt = res;
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            res_nxt[32*(NB-1-int'(col_idx + 2'(g))) +: 32] = col_mix[g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            col_idx <= '0;
            src     <= '0;
            inv_r   <= 1'b0;
            res     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src     <= state_in;
                inv_r   <= inv;
                col_idx <= '0;
            end else if (state == ST_BUSY) begin
                col_idx <= col_idx + COL_STEP;
                res     <= res_nxt;
            end
        end
    end

endmodule
